// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall bit
// values, the per-cause stall patterns and the multi-cycle FSM encoding.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // stall vector bit order: {WB, MEM, EX, ID, IF, PC}
    localparam logic [5:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    localparam logic [5:0] STALL_IF   = {NoStop, NoStop, NoStop, NoStop, Stop,   Stop};
    localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
    localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
    localparam logic [5:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and pipe_ctrl.
// Request/response semantics: every *req input is a level that the stage
// holds for as long as its condition lasts; the controller answers in the
// same cycle through stall/flush, which the pipeline registers sample at
// the next rising edge. There is no separate acknowledge: a request is
// served when the stall vector releases the requesting stage.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CW = 5
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             ex_mc_req;
    logic [MC_CW-1:0] ex_mc_cycles;
    logic             stallreq_mem;
    logic             flush_req;
    logic [5:0]       stall;
    logic             flush;
    logic             mc_busy;
    logic             mc_done;
    logic             bus_timeout;
    // debug view of the multi-cycle sequencer
    mc_state_e        mc_state;
    logic [MC_CW-1:0] mc_cnt;

    modport master (
        output stallreq_if, stallreq_id, ex_mc_req, ex_mc_cycles,
               stallreq_mem, flush_req,
        input  stall, flush, mc_busy, mc_done, bus_timeout, mc_state, mc_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, ex_mc_req, ex_mc_cycles,
               stallreq_mem, flush_req,
        output stall, flush, mc_busy, mc_done, bus_timeout, mc_state, mc_cnt
    );
endinterface

// File: rtl/pipe_ctrl_mc_fsm.sv
// Multi-cycle EX sequencer (ctrl_mc_fsm): holds EX for N = max(cycles,1)
// cycles, then gives one DONE cycle. A memory stall freezes everything;
// a flush drops the op.
module pipe_ctrl_mc_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mc_req_i,
    input  logic [MC_CW-1:0] mc_cycles_i,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    output logic             ex_stall_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output mc_state_e        state_o,
    output logic [MC_CW-1:0] cnt_o
);
    mc_state_e        state_q, state_d;
    logic [MC_CW-1:0] cnt_q, cnt_d;
    logic [MC_CW-1:0] n_cyc;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and per-state outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_stall_o = 1'b0;
        mc_busy_o  = 1'b0;
        mc_done_o  = 1'b0;
        n_cyc      = (mc_cycles_i == '0) ? MC_CW'(1) : mc_cycles_i;
        case (state_q)
            MC_IDLE: begin
                ex_stall_o = mc_req_i;
                mc_busy_o  = mc_req_i;
                // a memory stall holds the op back until the bus is free
                if (mc_req_i && !mem_stall_i) begin
                    if (n_cyc == MC_CW'(1)) begin
                        state_d = MC_DONE;
                    end else begin
                        cnt_d   = n_cyc - MC_CW'(1);
                        state_d = MC_BUSY;
                    end
                end
            end
            MC_BUSY: begin
                ex_stall_o = 1'b1;
                mc_busy_o  = 1'b1;
                if (!mem_stall_i) begin
                    if (cnt_q == MC_CW'(1)) begin
                        cnt_d   = '0;
                        state_d = MC_DONE;
                    end else begin
                        cnt_d = cnt_q - MC_CW'(1);
                    end
                end
            end
            MC_DONE: begin
                mc_done_o = 1'b1;
                if (!mem_stall_i) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
        // flush drops the op and masks the done strobe in this cycle
        if (flush_i) begin
            state_d   = MC_IDLE;
            cnt_d     = '0;
            mc_done_o = 1'b0;
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority mux over the stall causes,
// exception flush, multi-cycle sequencer and a hung-bus watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CW       = 5,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    logic          ex_stall;
    logic          fsm_busy;
    logic          fsm_done;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tout_q, tout_d;

    pipe_ctrl_mc_fsm #(.MC_CW(MC_CW)) u_mc_fsm (
        .clk         (clk),
        .rst         (rst),
        .mc_req_i    (bus.ex_mc_req),
        .mc_cycles_i (bus.ex_mc_cycles),
        .mem_stall_i (bus.stallreq_mem),
        .flush_i     (bus.flush_req),
        .ex_stall_o  (ex_stall),
        .mc_busy_o   (fsm_busy),
        .mc_done_o   (fsm_done),
        .state_o     (bus.mc_state),
        .cnt_o       (bus.mc_cnt)
    );

    // Priority mux: flush > mem > EX multi-cycle > id > if; silent in reset
    always_comb begin
        bus.stall = STALL_NONE;
        bus.flush = 1'b0;
        if (!rst) begin
            bus.stall = STALL_NONE;
        end else if (bus.flush_req) begin
            bus.flush = 1'b1;
        end else if (bus.stallreq_mem) begin
            bus.stall = STALL_MEM;
        end else if (ex_stall) begin
            bus.stall = STALL_EX;
        end else if (bus.stallreq_id) begin
            bus.stall = STALL_ID;
        end else if (bus.stallreq_if) begin
            bus.stall = STALL_IF;
        end
    end

    assign bus.mc_busy = rst & fsm_busy;
    assign bus.mc_done = rst & fsm_done;

    // Watchdog next state: count consecutive mem waits, pulse on the limit
    always_comb begin
        tcnt_d = '0;
        tout_d = 1'b0;
        if (bus.stallreq_mem && !bus.flush_req) begin
            if (tcnt_q == TW'(BUS_TIMEOUT - 1)) begin
                tout_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tout_q <= tout_d;
        end
    end

    assign bus.bus_timeout = tout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: reset, table of priority vectors, directed
// multi-cycle / flush / watchdog sequences and randomized traffic against
// a cycle-level reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW = 5;
    localparam int TO = 255;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_ctrl_if #(.MC_CW(CW)) bus ();

    pipe_ctrl #(.MC_CW(CW), .BUS_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: remaining EX-stall cycles, pending done, watchdog
    int m_rem;
    bit m_done;
    int m_tcnt;
    bit m_pulse;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem   = 0;
        m_done  = 1'b0;
        m_tcnt  = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_check();
        bit         idle;
        bit         ex;
        int         n;
        logic [5:0] e_stall;
        idle = (m_rem == 0) && !m_done;
        n    = (bus.ex_mc_cycles == 0) ? 1 : int'(bus.ex_mc_cycles);
        ex   = (m_rem > 0) || (idle && bus.ex_mc_req);
        if (bus.flush_req)         e_stall = 6'b000000;
        else if (bus.stallreq_mem) e_stall = 6'b011111;
        else if (ex)               e_stall = 6'b001111;
        else if (bus.stallreq_id)  e_stall = 6'b000111;
        else if (bus.stallreq_if)  e_stall = 6'b000011;
        else                       e_stall = 6'b000000;
        chk("model stall", 32'(bus.stall), 32'(e_stall));
        chk("model flush", 32'(bus.flush), 32'(bus.flush_req));
        chk("model mc_busy", 32'(bus.mc_busy), 32'(ex));
        chk("model mc_done", 32'(bus.mc_done), 32'(m_done && !bus.flush_req));
        chk("model bus_timeout", 32'(bus.bus_timeout), 32'(m_pulse));
        // advance to the next edge
        if (bus.flush_req) begin
            m_rem  = 0;
            m_done = 1'b0;
        end else if (!bus.stallreq_mem) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end else if (bus.ex_mc_req) begin
                m_rem = n - 1;
                if (m_rem == 0) m_done = 1'b1;
            end
        end
        if (bus.stallreq_mem && !bus.flush_req) begin
            m_tcnt++;
            m_pulse = (m_tcnt == TO);
            if (m_tcnt == TO) m_tcnt = 0;
        end else begin
            m_tcnt  = 0;
            m_pulse = 1'b0;
        end
    endtask

    // driver tasks
    task automatic set_in(input bit f_if, input bit f_id, input bit req,
                          input int cyc, input bit mem, input bit fl);
        bus.stallreq_if  = f_if;
        bus.stallreq_id  = f_id;
        bus.ex_mc_req    = req;
        bus.ex_mc_cycles = CW'(cyc);
        bus.stallreq_mem = mem;
        bus.flush_req    = fl;
    endtask

    task automatic next_cycle();
        model_check();
        @(posedge clk);
        #1;
    endtask

    // one directed cycle with hand-written stall/done expectations
    task automatic cx(input string nm, input logic [5:0] e_stall, input bit e_done);
        #3;
        chk({nm, " stall"}, 32'(bus.stall), 32'(e_stall));
        chk({nm, " mc_done"}, 32'(bus.mc_done), 32'(e_done));
        next_cycle();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " stall"}, 32'(bus.stall), 32'd0);
        chk({nm, " flush"}, 32'(bus.flush), 32'd0);
        chk({nm, " mc_busy"}, 32'(bus.mc_busy), 32'd0);
        chk({nm, " mc_done"}, 32'(bus.mc_done), 32'd0);
        chk({nm, " bus_timeout"}, 32'(bus.bus_timeout), 32'd0);
    endtask

    // reset with all requests active: outputs must still be quiet
    task automatic do_reset();
        set_in(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk_all_zero("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         f_if;
        bit         f_id;
        bit         req;
        int         cyc;
        bit         mem;
        bit         fl;
        logic [5:0] e_stall;
        bit         e_flush;
    } vec_t;

    vec_t vecs[10];
    int   pulses;
    int   pulse_at;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        #2;
        do_reset();

        // priority vectors from IDLE
        vecs[0] = '{0, 0, 0, 0, 0, 0, 6'b000000, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 6'b000011, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 6'b000111, 0};
        vecs[3] = '{1, 1, 0, 0, 0, 0, 6'b000111, 0};
        vecs[4] = '{0, 0, 0, 0, 1, 0, 6'b011111, 0};
        vecs[5] = '{1, 1, 0, 0, 1, 0, 6'b011111, 0};
        vecs[6] = '{1, 1, 1, 3, 1, 0, 6'b011111, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 1, 6'b000000, 1};
        vecs[8] = '{1, 1, 1, 3, 1, 1, 6'b000000, 1};
        vecs[9] = '{0, 0, 1, 3, 0, 1, 6'b000000, 1};
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].f_if, vecs[i].f_id, vecs[i].req, vecs[i].cyc, vecs[i].mem, vecs[i].fl);
            #3;
            chk($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("idle after vectors", 32'(bus.mc_state), 32'(MC_IDLE));
        next_cycle();

        // N=3: three EX-stall cycles, one done cycle, then idle
        set_in(0, 0, 1, 3, 0, 0);
        cx("n3 c1", 6'b001111, 0);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("n3 cnt", 32'(bus.mc_cnt), 32'd2);
        cx("n3 c2", 6'b001111, 0);
        cx("n3 c3", 6'b001111, 0);
        cx("n3 done", 6'b000000, 1);
        cx("n3 idle", 6'b000000, 0);

        // cycles=0 behaves as 1
        set_in(0, 0, 1, 0, 0, 0);
        cx("n0 c1", 6'b001111, 0);
        set_in(0, 0, 0, 0, 0, 0);
        cx("n0 done", 6'b000000, 1);
        cx("n0 idle", 6'b000000, 0);

        // N=4, memory stall for 4 cycles with cnt at 2
        set_in(0, 0, 1, 4, 0, 0);
        cx("frz c1", 6'b001111, 0);
        set_in(0, 0, 0, 0, 0, 0);
        cx("frz c2", 6'b001111, 0);
        set_in(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz cnt held", 32'(bus.mc_cnt), 32'd2);
            cx("frz mem", 6'b011111, 0);
        end
        set_in(0, 1, 0, 0, 0, 0);
        cx("frz c3", 6'b001111, 0);
        cx("frz c4", 6'b001111, 0);
        set_in(0, 0, 0, 0, 0, 0);
        cx("frz done", 6'b000000, 1);
        cx("frz idle", 6'b000000, 0);

        // done held by a memory stall
        set_in(0, 0, 1, 1, 0, 0);
        cx("dh c1", 6'b001111, 0);
        set_in(0, 0, 0, 0, 1, 0);
        cx("dh mem", 6'b011111, 1);
        set_in(0, 0, 0, 0, 0, 0);
        cx("dh done", 6'b000000, 1);
        cx("dh idle", 6'b000000, 0);

        // flush during BUSY
        set_in(0, 0, 1, 5, 0, 0);
        cx("fl c1", 6'b001111, 0);
        set_in(0, 0, 0, 0, 0, 1);
        #3;
        chk("fl flush", 32'(bus.flush), 32'd1);
        cx("fl cyc", 6'b000000, 0);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("fl state", 32'(bus.mc_state), 32'(MC_IDLE));
        cx("fl after1", 6'b000000, 0);
        cx("fl after2", 6'b000000, 0);

        // flush together with a new multi-cycle request
        set_in(0, 0, 1, 3, 0, 1);
        cx("flreq", 6'b000000, 0);
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("flreq busy", 32'(bus.mc_busy), 32'd0);
        chk("flreq state", 32'(bus.mc_state), 32'(MC_IDLE));
        next_cycle();

        // watchdog: 300 consecutive memory waits
        pulses   = 0;
        pulse_at = 0;
        set_in(0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 300; i++) begin
            #3;
            if (bus.bus_timeout === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            next_cycle();
        end
        chk("timeout pulse count", 32'(pulses), 32'd1);
        chk("timeout pulse cycle", 32'(pulse_at), 32'd256);
        set_in(1, 1, 1, 3, 1, 0);
        rst = 1'b0;
        #1;
        chk_all_zero("mid-run reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
            #3;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline stall/flush controller for the five-stage CPU. It merges per-stage stall requests into the 6-bit `stall` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and sequences multi-cycle EX operations (mul/div) with an internal counter FSM. It also raises an exception flush and watches for hung data-bus waits. It sits beside the pipeline, purely as a control block; it owns no datapath registers.

## Interface
- `MC_CW`, default 5: width of the multi-cycle length field.
- `BUS_TIMEOUT`, default 255: number of consecutive `stallreq_mem` cycles before `bus_timeout` fires.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stallreq_if`  in  1  instruction fetch waiting on bus
- `stallreq_id`  in  1  load-use hazard detected in ID
- `ex_mc_req`  in  1  multi-cycle op present in EX; sampled only in IDLE
- `ex_mc_cycles`  in  MC_CW  EX-stall length of that op; 0 is treated as 1
- `stallreq_mem`  in  1  data access waiting on bus
- `flush_req`  in  1  exception/eret flush request
- `stall`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = `Stop`
- `flush`  out  1  clear all pipeline registers this edge
- `mc_busy`  out  1  FSM in REQ-accepted or BUSY
- `mc_done`  out  1  EX may capture the multi-cycle result
- `bus_timeout`  out  1  one-cycle pulse on hung memory wait

## Operation
- `stall` and `flush` are combinational from the inputs and FSM state. Pipeline registers sample them at the same edge.
- Priority is flush > mem > EX multi-cycle > id > if. Patterns:
  - flush: `stall`=000000, `flush`=1
  - mem: 011111
  - EX stall: 001111
  - id: 000111
  - if: 000011
  - none: 000000
- EX stall is asserted when (IDLE and `ex_mc_req`) or state==BUSY.
- FSM states are IDLE, BUSY and DONE. N = max(`ex_mc_cycles`, 1).
  - IDLE & `ex_mc_req`: if N==1 go to DONE; otherwise load cnt=N-1 and go to BUSY.
  - BUSY: cnt decrements each cycle; at cnt==1 go to DONE.
  - DONE: `mc_done`=1 and there is no EX stall from the FSM; go to IDLE.
- Net effect: EX is stalled exactly N cycles, followed by one DONE cycle.
- `stallreq_mem` freezes cnt and state (BUSY and DONE both hold). `mc_done` stays high until a DONE cycle without a mem stall.
- `ex_mc_req` is ignored outside IDLE.
- `flush_req` forces the FSM to IDLE and cnt to 0 at the next edge. It also overrides everything in the current cycle, including `mc_done` (forced 0).
- Timeout counter:
  - Increments while `stallreq_mem`=1 and `flush_req`=0, and clears otherwise.
  - When it reaches `BUSY_TIMEOUT`… correction, when it reaches `BUS_TIMEOUT`, `bus_timeout` pulses one cycle (registered) and the counter clears. This is reported only; `stall` is not altered.
- `mc_busy` = state is BUSY, or IDLE with `ex_mc_req`.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt 0, timeout counter 0.
  - Outputs during reset: `stall`=0, `flush`=0, `mc_busy`=0, `mc_done`=0, `bus_timeout`=0, all forced regardless of inputs.
- Reset released mid-BUSY: the FSM restarts in IDLE, and the interrupted op is lost, as intended.
- Latency:
  - Stall and flush have zero-cycle latency (combinational).
  - FSM transitions and `bus_timeout` take effect on the next rising edge.
- Simultaneous events:
  - `flush_req` together with `ex_mc_req`: flush wins and the op is not started.
  - `stallreq_id` during BUSY: the EX pattern already covers ID, so there is no extra effect.
- Counter wrap: cnt never underflows, because it is only decremented while >1.

## Structure
- Add to define.vh:
  - `Stop`/`NoStop`
  - stall patterns `STALL_NONE/IF/ID/EX/MEM`
  - FSM encodings `MC_IDLE=2'd0`, `MC_BUSY=2'd1`, `MC_DONE=2'd2`
- One sub-module, `ctrl_mc_fsm`, containing the FSM, cnt, `mc_busy`, `mc_done` and the EX stall request.
- Top-level `pipe_ctrl` holds the priority mux, flush and timeout counter.

## Test plan
- `ex_mc_req`=1 with `ex_mc_cycles`=3, no other requests → `stall`=001111 for 3 cycles, then `mc_done`=1 with `stall`=0 for 1 cycle, then IDLE.
- `ex_mc_cycles`=0 → behaves as 1: one stalled cycle, then DONE.
- BUSY with cnt=2 and `stallreq_mem` held 4 cycles → `stall`=011111 for 4 cycles and cnt frozen at 2, then 2 more EX-stall cycles, then DONE.
- `flush_req` during BUSY → `stall`=0 and `flush`=1 that cycle, then IDLE next cycle with `mc_done` never asserted.
- `stallreq_id`=1 and `stallreq_if`=1 together → 000111; `stallreq_if` alone → 000011.
- `stallreq_mem` held 300 cycles with `BUS_TIMEOUT`=255 → exactly one `bus_timeout` pulse, on the cycle after the 255th wait cycle. Assert `rst`=0 mid-run → all outputs 0 immediately.
